// File: rtl/hdmi_pkg.sv
// Shared types and helpers for the HDMI pixel-stream stages: RGB pixel,
// sync bundle, bounding-box FSM states and the integer luma approximation.
package hdmi_pkg;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb24_t;

   typedef struct packed {
      logic de;
      logic hs;
      logic vs;
   } sync_t;

   typedef enum logic {
      WAIT_VS = 1'b0,
      ACCUM   = 1'b1
   } bbox_state_t;

   // Y = (R + 2G + B) / 4; the 10-bit sum cannot overflow (max 1020).
   function automatic logic [7:0] luma(input rgb24_t p);
      logic [9:0] sum;
      sum = {2'b00, p.r} + {1'b0, p.g, 1'b0} + {2'b00, p.b};
      return sum[9:2];
   endfunction

endpackage

// File: rtl/hdmi_xy_counter.sv
// Position of the pixel currently on the input bus (x = column, y = row),
// plus the de-fall and vs-rise strobes; reusable by any stream stage.
module hdmi_xy_counter #(
   parameter int IMG_W = 64,
   parameter int IMG_H = 64
) (
   input  logic                     hdmi_clk,
   input  logic                     rst,
   input  logic                     i_de,
   input  logic                     i_vs,
   output logic [$clog2(IMG_W)-1:0] o_x,
   output logic [$clog2(IMG_H)-1:0] o_y,
   output logic                     o_de_fall,
   output logic                     o_vs_rise
);

   localparam int XW = $clog2(IMG_W);
   localparam int YW = $clog2(IMG_H);
   localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

   logic          r_de_d;
   logic          r_vs_d;
   logic [XW-1:0] r_x;
   logic [YW-1:0] r_y;
   logic          w_de_fall;
   logic          w_vs_rise;

   assign w_de_fall = r_de_d & ~i_de;
   assign w_vs_rise = i_vs & ~r_vs_d;

   // NOTE: non-blocking (<=) in clocked blocks so every register sees pre-edge values.
   always_ff @(posedge hdmi_clk) begin
      if (rst) begin
         r_de_d <= 1'b0;
         r_vs_d <= 1'b0;
         r_x    <= '0;
         r_y    <= '0;
      end else begin
         r_de_d <= i_de;
         r_vs_d <= i_vs;

         if (i_de) begin
            if (r_x != X_LAST)
               r_x <= r_x + 1'b1;
         end else if (w_de_fall) begin
            r_x <= '0;
         end

         // Frame start wins over a line end landing on the same cycle.
         if (w_vs_rise)
            r_y <= '0;
         else if (w_de_fall && (r_y != Y_LAST))
            r_y <= r_y + 1'b1;
      end
   end

   assign o_x       = r_x;
   assign o_y       = r_y;
   assign o_de_fall = w_de_fall;
   assign o_vs_rise = w_vs_rise;

endmodule

// File: rtl/hdmi_bbox_overlay.sv
// Finds the bounding box of above-threshold luma pixels in each frame and
// draws the previous frame's box onto the 2-clock delayed pixel stream.
module hdmi_bbox_overlay
   import hdmi_pkg::*;
#(
   parameter int          IMG_W   = 64,
   parameter int          IMG_H   = 64,
   parameter logic [7:0]  THRESH  = 8'd128,
   parameter logic [23:0] BOX_RGB = 24'hFF0000
) (
   input  logic                     hdmi_clk,
   input  logic                     rst,
   input  logic                     overlay_en,
   input  logic                     in_de,
   input  logic                     in_hs,
   input  logic                     in_vs,
   input  logic [7:0]               in_r,
   input  logic [7:0]               in_g,
   input  logic [7:0]               in_b,
   output logic                     out_de,
   output logic                     out_hs,
   output logic                     out_vs,
   output logic [7:0]               out_r,
   output logic [7:0]               out_g,
   output logic [7:0]               out_b,
   output logic                     bbox_valid,
   output logic [$clog2(IMG_W)-1:0] bbox_xmin,
   output logic [$clog2(IMG_W)-1:0] bbox_xmax,
   output logic [$clog2(IMG_H)-1:0] bbox_ymin,
   output logic [$clog2(IMG_H)-1:0] bbox_ymax,
   output logic                     frame_done
);

   localparam int XW = $clog2(IMG_W);
   localparam int YW = $clog2(IMG_H);
   localparam logic [XW-1:0] X_LAST  = XW'(IMG_W - 1);
   localparam logic [YW-1:0] Y_LAST  = YW'(IMG_H - 1);
   localparam rgb24_t        BOX_PIX = rgb24_t'(BOX_RGB);

   logic [XW-1:0] w_x;
   logic [YW-1:0] w_y;
   logic          w_vs_rise;
   logic          w_unused_de_fall;
   rgb24_t        w_in_pix;
   sync_t         w_in_sync;
   logic          w_fg;
   logic          w_hit;

   bbox_state_t   r_state;
   logic [XW-1:0] r_acc_xmin;
   logic [XW-1:0] r_acc_xmax;
   logic [YW-1:0] r_acc_ymin;
   logic [YW-1:0] r_acc_ymax;
   logic          r_acc_found;
   logic          r_bbox_valid;
   logic [XW-1:0] r_bbox_xmin;
   logic [XW-1:0] r_bbox_xmax;
   logic [YW-1:0] r_bbox_ymin;
   logic [YW-1:0] r_bbox_ymax;
   logic          r_frame_done;

   sync_t         r_s1_sync;
   rgb24_t        r_s1_pix;
   logic [XW-1:0] r_s1_x;
   logic [YW-1:0] r_s1_y;
   sync_t         r_out_sync;
   rgb24_t        r_out_pix;

   // Line-end strobe is not needed here; other stages consume it.
   hdmi_xy_counter #(
      .IMG_W (IMG_W),
      .IMG_H (IMG_H)
   ) u_xy (
      .hdmi_clk  (hdmi_clk),
      .rst       (rst),
      .i_de      (in_de),
      .i_vs      (in_vs),
      .o_x       (w_x),
      .o_y       (w_y),
      .o_de_fall (w_unused_de_fall),
      .o_vs_rise (w_vs_rise)
   );

   assign w_in_pix  = {in_r, in_g, in_b};
   assign w_in_sync = {in_de, in_hs, in_vs};
   assign w_fg      = in_de & (luma(w_in_pix) > THRESH);

   always_ff @(posedge hdmi_clk) begin
      if (rst) begin
         r_state      <= WAIT_VS;
         r_acc_xmin   <= X_LAST;
         r_acc_xmax   <= '0;
         r_acc_ymin   <= Y_LAST;
         r_acc_ymax   <= '0;
         r_acc_found  <= 1'b0;
         r_bbox_valid <= 1'b0;
         r_bbox_xmin  <= '0;
         r_bbox_xmax  <= '0;
         r_bbox_ymin  <= '0;
         r_bbox_ymax  <= '0;
         r_frame_done <= 1'b0;
      end else begin
         r_frame_done <= 1'b0;
         case (r_state)
            WAIT_VS: begin
               // A frame already in flight is incomplete; start clean at the next vsync.
               if (w_vs_rise)
                  r_state <= ACCUM;
            end
            ACCUM: begin
               if (w_vs_rise) begin
                  r_bbox_valid <= r_acc_found;
                  r_bbox_xmin  <= r_acc_xmin;
                  r_bbox_xmax  <= r_acc_xmax;
                  r_bbox_ymin  <= r_acc_ymin;
                  r_bbox_ymax  <= r_acc_ymax;
                  r_frame_done <= 1'b1;
                  r_acc_xmin   <= X_LAST;
                  r_acc_xmax   <= '0;
                  r_acc_ymin   <= Y_LAST;
                  r_acc_ymax   <= '0;
                  r_acc_found  <= 1'b0;
               end else if (w_fg) begin
                  if (w_x < r_acc_xmin) r_acc_xmin <= w_x;
                  if (w_x > r_acc_xmax) r_acc_xmax <= w_x;
                  if (w_y < r_acc_ymin) r_acc_ymin <= w_y;
                  if (w_y > r_acc_ymax) r_acc_ymax <= w_y;
                  r_acc_found <= 1'b1;
               end
            end
            default: r_state <= WAIT_VS;
         endcase
      end
   end

   always_ff @(posedge hdmi_clk) begin
      if (rst) begin
         r_s1_sync <= '0;
         r_s1_pix  <= '0;
         r_s1_x    <= '0;
         r_s1_y    <= '0;
      end else begin
         r_s1_sync <= w_in_sync;
         r_s1_pix  <= w_in_pix;
         r_s1_x    <= w_x;
         r_s1_y    <= w_y;
      end
   end

   // r_s1_sync.de becomes out_de on the same edge that registers the drawn pixel.
   always_comb begin
      // NOTE: default assigned first so the combinational hit flag cannot infer a latch.
      w_hit = 1'b0;
      if (overlay_en && r_bbox_valid && r_s1_sync.de) begin
         if (((r_s1_x == r_bbox_xmin) || (r_s1_x == r_bbox_xmax)) &&
             (r_s1_y >= r_bbox_ymin) && (r_s1_y <= r_bbox_ymax))
            w_hit = 1'b1;
         if (((r_s1_y == r_bbox_ymin) || (r_s1_y == r_bbox_ymax)) &&
             (r_s1_x >= r_bbox_xmin) && (r_s1_x <= r_bbox_xmax))
            w_hit = 1'b1;
      end
   end

   always_ff @(posedge hdmi_clk) begin
      if (rst) begin
         r_out_sync <= '0;
         r_out_pix  <= '0;
      end else begin
         r_out_sync <= r_s1_sync;
         r_out_pix  <= w_hit ? BOX_PIX : r_s1_pix;
      end
   end

   assign out_de     = r_out_sync.de;
   assign out_hs     = r_out_sync.hs;
   assign out_vs     = r_out_sync.vs;
   assign out_r      = r_out_pix.r;
   assign out_g      = r_out_pix.g;
   assign out_b      = r_out_pix.b;
   assign bbox_valid = r_bbox_valid;
   assign bbox_xmin  = r_bbox_xmin;
   assign bbox_xmax  = r_bbox_xmax;
   assign bbox_ymin  = r_bbox_ymin;
   assign bbox_ymax  = r_bbox_ymax;
   assign frame_done = r_frame_done;

endmodule

// File: tb/tb_hdmi_bbox_overlay.sv
// Scoreboard bench: a 64x64 source drives directed frames and queues the
// expected delayed pixels and box reports; a negedge monitor pops and compares.
module tb_hdmi_bbox_overlay;
   import hdmi_pkg::*;

   localparam int W    = 64;
   localparam int H    = 64;
   localparam int LINE = W + 4;

   localparam int K_BLACK  = 0;
   localparam int K_RECT   = 1;
   localparam int K_DOT129 = 2;
   localparam int K_DOT128 = 3;

   localparam rgb24_t BOX   = 24'hFF0000;
   localparam rgb24_t WHITE = 24'hFFFFFF;
   localparam rgb24_t BLACK = 24'h000000;

   typedef struct {
      int          due;
      logic [26:0] v;
   } pix_exp_t;

   typedef struct {
      int         due;
      logic       valid;
      logic [5:0] xmin;
      logic [5:0] xmax;
      logic [5:0] ymin;
      logic [5:0] ymax;
   } rep_t;

   logic       hdmi_clk = 1'b0;
   logic       rst = 1'b1;
   logic       overlay_en = 1'b0;
   logic       in_de = 1'b0, in_hs = 1'b0, in_vs = 1'b0;
   logic [7:0] in_r = '0, in_g = '0, in_b = '0;
   logic       out_de, out_hs, out_vs;
   logic [7:0] out_r, out_g, out_b;
   logic       bbox_valid, frame_done;
   logic [5:0] bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax;

   pix_exp_t pq[$];
   rep_t     rq[$];
   int       cyc = 0;
   logic     rst_at_edge = 1'b0;
   int       n_tests = 0;
   int       n_fail = 0;
   logic     exp_valid = 1'b0;
   int       exp_xmin = 0, exp_xmax = 0, exp_ymin = 0, exp_ymax = 0;

   always #5 hdmi_clk = ~hdmi_clk;

   hdmi_bbox_overlay #(
      .IMG_W   (W),
      .IMG_H   (H),
      .THRESH  (8'd128),
      .BOX_RGB (24'hFF0000)
   ) dut (
      .hdmi_clk   (hdmi_clk),
      .rst        (rst),
      .overlay_en (overlay_en),
      .in_de      (in_de),
      .in_hs      (in_hs),
      .in_vs      (in_vs),
      .in_r       (in_r),
      .in_g       (in_g),
      .in_b       (in_b),
      .out_de     (out_de),
      .out_hs     (out_hs),
      .out_vs     (out_vs),
      .out_r      (out_r),
      .out_g      (out_g),
      .out_b      (out_b),
      .bbox_valid (bbox_valid),
      .bbox_xmin  (bbox_xmin),
      .bbox_xmax  (bbox_xmax),
      .bbox_ymin  (bbox_ymin),
      .bbox_ymax  (bbox_ymax),
      .frame_done (frame_done)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
      end
   endtask

   function automatic rgb24_t src_pix(input int kind, input int c, input int rw);
      rgb24_t p;
      p = BLACK;
      case (kind)
         K_RECT:   if (c >= 10 && c <= 20 && rw >= 5 && rw <= 30) p = WHITE;
         K_DOT129: if (c == 63 && rw == 63) p = {8'd129, 8'd129, 8'd129};
         K_DOT128: if (c == 63 && rw == 63) p = {8'd128, 8'd128, 8'd128};
         default:  p = BLACK;
      endcase
      return p;
   endfunction

   function automatic logic on_box(input int c, input int rw);
      return ((c == exp_xmin || c == exp_xmax) && rw >= exp_ymin && rw <= exp_ymax) ||
             ((rw == exp_ymin || rw == exp_ymax) && c >= exp_xmin && c <= exp_xmax);
   endfunction

   // One input cycle; the pixel it carries must appear two clocks later, or as
   // zero wherever reset lands on its path through the pipeline.
   task automatic drive(input logic de, input logic hs, input logic vs,
                        input rgb24_t pix, input logic r, input logic draw);
      pix_exp_t e;
      pix_exp_t last;
      rst   = r;
      in_de = de;
      in_hs = hs;
      in_vs = vs;
      {in_r, in_g, in_b} = pix;
      if (r && pq.size() > 0 && pq[pq.size()-1].due == cyc + 1) begin
         last   = pq.pop_back();
         last.v = '0;
         pq.push_back(last);
      end
      e.due = cyc + 2;
      e.v   = r ? 27'd0 : {de, hs, vs, (draw ? BOX : pix)};
      pq.push_back(e);
      @(posedge hdmi_clk);
      #1;
   endtask

   // One frame: a vblank line opening with the vsync edge, then H active lines.
   task automatic frame(input int kind, input logic ov, input logic rep_en, input logic rep_valid,
                        input int xmin, input int xmax, input int ymin, input int ymax,
                        input int rst_line, input logic vs_pix);
      rep_t   rr;
      logic   de, hs, r, draw;
      rgb24_t pix;
      overlay_en = ov;
      if (rep_en) begin
         rr.due   = cyc + 1;
         rr.valid = rep_valid;
         rr.xmin  = 6'(xmin);
         rr.xmax  = 6'(xmax);
         rr.ymin  = 6'(ymin);
         rr.ymax  = 6'(ymax);
         rq.push_back(rr);
      end
      exp_valid = rep_en & rep_valid;
      exp_xmin  = xmin;
      exp_xmax  = xmax;
      exp_ymin  = ymin;
      exp_ymax  = ymax;
      for (int c = 0; c < LINE; c++) begin
         hs = (c == W + 1) || (c == W + 2);
         if (c == 0 && vs_pix) drive(1'b1, hs, 1'b1, WHITE, 1'b0, 1'b0);
         else                  drive(1'b0, hs, c < 8, BLACK, 1'b0, 1'b0);
      end
      for (int rw = 0; rw < H; rw++) begin
         for (int c = 0; c < LINE; c++) begin
            de   = c < W;
            hs   = (c == W + 1) || (c == W + 2);
            pix  = de ? src_pix(kind, c, rw) : BLACK;
            r    = (rw == rst_line) && (c == 20 || c == 21);
            draw = ov & exp_valid & de & on_box(c, rw);
            drive(de, hs, 1'b0, pix, r, draw);
         end
      end
   endtask

   always @(posedge hdmi_clk) begin
      cyc++;
      rst_at_edge = rst;
   end

   always @(negedge hdmi_clk) begin : monitor
      pix_exp_t p;
      rep_t     r;
      if (rst_at_edge)
         check("reset_state", 64'({bbox_valid, frame_done, bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax}), 64'd0);
      while (pq.size() > 0 && pq[0].due < cyc) begin
         p = pq.pop_front();
         check("pixel_missed", 64'(p.due), 64'(cyc));
      end
      if (pq.size() > 0 && pq[0].due == cyc) begin
         p = pq.pop_front();
         check("pixel", 64'({out_de, out_hs, out_vs, out_r, out_g, out_b}), 64'(p.v));
      end
      if (frame_done) begin
         if (rq.size() > 0 && rq[0].due == cyc) begin
            r = rq.pop_front();
            check("bbox_report", 64'({bbox_valid, bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax}),
                  64'({r.valid, r.xmin, r.xmax, r.ymin, r.ymax}));
         end else begin
            check("unexpected_frame_done", 64'(frame_done), 64'd0);
         end
      end else begin
         while (rq.size() > 0 && rq[0].due <= cyc) begin
            r = rq.pop_front();
            check("missing_frame_done", 64'(frame_done), 64'd1);
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: reached cycle %0d, expected the run to end first", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      @(posedge hdmi_clk);
      #1;
      repeat (4) drive(1'b0, 1'b0, 1'b0, BLACK, 1'b1, 1'b0);
      repeat (2) drive(1'b0, 1'b0, 1'b0, BLACK, 1'b0, 1'b0);

      // S1: first edge after reset only arms; black frames report an empty box.
      frame(K_BLACK,  1'b1, 1'b0, 1'b0, 63, 0, 63, 0, -1, 1'b0);
      frame(K_BLACK,  1'b1, 1'b1, 1'b0, 63, 0, 63, 0, -1, 1'b0);
      // S2: rectangle found, then drawn on the following frame.
      frame(K_RECT,   1'b1, 1'b1, 1'b0, 63, 0, 63, 0, -1, 1'b0);
      frame(K_RECT,   1'b1, 1'b1, 1'b1, 10, 20, 5, 30, -1, 1'b0);
      // S4: same stimulus with the overlay disabled.
      frame(K_RECT,   1'b0, 1'b1, 1'b1, 10, 20, 5, 30, -1, 1'b0);
      // S3: single pixel just above threshold, then exactly at threshold.
      frame(K_DOT129, 1'b1, 1'b1, 1'b1, 10, 20, 5, 30, -1, 1'b0);
      frame(K_DOT128, 1'b1, 1'b1, 1'b1, 63, 63, 63, 63, -1, 1'b0);
      frame(K_BLACK,  1'b1, 1'b1, 1'b0, 63, 0, 63, 0, -1, 1'b0);
      // S6: white de=1 pixel on the vsync edge belongs to neither frame.
      frame(K_BLACK,  1'b1, 1'b1, 1'b0, 63, 0, 63, 0, -1, 1'b1);
      // S5: reset in line 32; next edge silent, the one after reports.
      frame(K_RECT,   1'b0, 1'b1, 1'b0, 63, 0, 63, 0, 32, 1'b0);
      frame(K_RECT,   1'b0, 1'b0, 1'b0, 63, 0, 63, 0, -1, 1'b0);
      frame(K_BLACK,  1'b1, 1'b1, 1'b1, 10, 20, 5, 30, -1, 1'b0);

      repeat (8) drive(1'b0, 1'b0, 1'b0, BLACK, 1'b0, 1'b0);
      repeat (4) @(posedge hdmi_clk);
      #1;
      check("pixel_queue_drained", 64'(pq.size()), 64'd0);
      check("report_queue_drained", 64'(rq.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
